// File: rtl/tx_gearbox_if.sv
// Upstream/downstream signal bundle for the 64b66b transmit gearbox.
// master: the PCS side that supplies half-frames and watches ready/seq.
// slave : the gearbox itself.
interface tx_gearbox_if;
  logic [31:0] i_data;
  logic [1:0]  i_header;
  logic        o_ready;
  logic [5:0]  o_seq;
  logic [31:0] o_data;

  modport master (
    output i_data,
    output i_header,
    input  o_ready,
    input  o_seq,
    input  o_data
  );

  modport slave (
    input  i_data,
    input  i_header,
    output o_ready,
    output o_seq,
    output o_data
  );
endinterface

// File: rtl/tx_gearbox.sv
// 64b66b transmit synchronous gearbox, 32-bit datapath.
// One 66-bit frame arrives over two cycles (header + low half, then high
// half). Output is a continuous LSB-first 32-bit word stream. A 33-cycle
// sequence stalls upstream once per period to absorb the 66/64 ratio.
// The residue length is a pure function of the sequence count, so only
// the residue bits themselves need storage.
module tx_gearbox #(
  parameter bit REGISTER_OUTPUT = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  tx_gearbox_if.slave  gb
);

  localparam int DATA_WIDTH     = 32;
  localparam int HEADER_WIDTH   = 2;
  localparam int SEQUENCE_WIDTH = 6;
  localparam int BUF_WIDTH      = 66;
  localparam int APPEND_WIDTH   = 64;
  localparam logic [SEQUENCE_WIDTH-1:0] SEQ_LAST = 6'd32;

  logic [SEQUENCE_WIDTH-1:0] seq_r;
  logic [BUF_WIDTH-1:0]      buf_r;
  logic [DATA_WIDTH-1:0]     data_r;

  logic [6:0]                res_cnt_s;
  logic [6:0]                app_cnt_s;
  logic [APPEND_WIDTH-1:0]   app_s;
  logic [BUF_WIDTH-1:0]      stream_s;
  logic [DATA_WIDTH-1:0]     out_s;

  // Residue length, appended length and appended bits for this cycle.
  always_comb begin
    res_cnt_s = {1'b0, seq_r} + {6'd0, seq_r[0]};
    app_cnt_s = 7'd0;
    app_s     = {APPEND_WIDTH{1'b0}};
    if (seq_r == SEQ_LAST) begin
      app_cnt_s = 7'd0;
      app_s     = {APPEND_WIDTH{1'b0}};
    end else if (seq_r[0]) begin
      app_cnt_s = 7'd32;
      app_s     = {32'd0, gb.i_data};
    end else begin
      app_cnt_s = 7'd34;
      app_s     = {30'd0, gb.i_data, gb.i_header[HEADER_WIDTH-1:0]};
    end
  end

  // Bit-by-bit merge: buffered residue first, then freshly appended bits.
  always_comb begin : merge
    logic [6:0] idx;
    idx      = 7'd0;
    stream_s = {BUF_WIDTH{1'b0}};
    for (int j = 0; j < BUF_WIDTH; j++) begin
      idx = 7'(j) - res_cnt_s;
      if (7'(j) < res_cnt_s) begin
        stream_s[j] = buf_r[j];
      end else if (idx < app_cnt_s) begin
        stream_s[j] = app_s[idx[5:0]];
      end else begin
        stream_s[j] = 1'b0;
      end
    end
  end

  // Sequence counter, residue buffer and registered output word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      seq_r  <= 6'd0;
      buf_r  <= {BUF_WIDTH{1'b0}};
      data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      seq_r  <= (seq_r == SEQ_LAST) ? 6'd0 : seq_r + 6'd1;
      buf_r  <= {32'd0, stream_s[BUF_WIDTH-1:DATA_WIDTH]};
      data_r <= stream_s[DATA_WIDTH-1:0];
    end
  end

  // Output word source: registered copy or the live merge result.
  always_comb begin
    if (REGISTER_OUTPUT) begin
      out_s = data_r;
    end else if (i_reset) begin
      out_s = {DATA_WIDTH{1'b0}};
    end else begin
      out_s = stream_s[DATA_WIDTH-1:0];
    end
  end

  assign gb.o_data  = out_s;
  assign gb.o_seq   = seq_r;
  assign gb.o_ready = (seq_r != SEQ_LAST);

endmodule

// File: tb/tb_tx_gearbox.sv
// Directed bench for tx_gearbox: one registered-output and one
// combinational-output instance share identical stimulus.
module tb_tx_gearbox;

  logic i_clk = 1'b0;
  logic i_reset;

  always #5 i_clk = ~i_clk;

  tx_gearbox_if if_r ();
  tx_gearbox_if if_c ();

  tx_gearbox #(.REGISTER_OUTPUT(1'b1)) dut_r (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .gb      (if_r)
  );

  tx_gearbox #(.REGISTER_OUTPUT(1'b0)) dut_c (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .gb      (if_c)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_seq  = 0;
  bit mq[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (seq %0d): got %08h expected %08h", tag, exp_seq, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] h);
    if_r.i_data   = d;
    if_r.i_header = h;
    if_c.i_data   = d;
    if_c.i_header = h;
  endtask

  // Called at posedge+1; checks this cycle and the registered copy next cycle.
  task automatic run_cycle(input logic [31:0] d, input logic [1:0] h, input logic [31:0] exp_word);
    drive(d, h);
    #1;
    check_val("seq_reg_dut", {26'd0, if_r.o_seq}, 32'(exp_seq));
    check_val("seq_comb_dut", {26'd0, if_c.o_seq}, 32'(exp_seq));
    check_val("ready", {31'd0, if_r.o_ready}, (exp_seq != 32) ? 32'd1 : 32'd0);
    check_val("data_comb", if_c.o_data, exp_word);
    @(posedge i_clk);
    #1;
    check_val("data_reg", if_r.o_data, exp_word);
    exp_seq = (exp_seq == 32) ? 0 : exp_seq + 1;
  endtask

  // Hand-derived stream: frames of header 2'b10 and zero data, optionally
  // with frame 0 replaced by header 2'b01, low half all-ones, high half zero.
  function automatic logic hand_bit(input int b, input bit special);
    if (special && b < 66) begin
      return (b == 0) || (b >= 2 && b <= 33);
    end
    return (b % 66) == 1;
  endfunction

  function automatic logic [31:0] hand_word(input int n, input bit special);
    logic [31:0] w;
    for (int j = 0; j < 32; j++) w[j] = hand_bit(32 * n + j, special);
    return w;
  endfunction

  // Bit-queue reference: append per sequence slot, pop 32 bits per cycle.
  task automatic model_step(input int s, input logic [31:0] d, input logic [1:0] h,
                            output logic [31:0] w);
    if (s != 32) begin
      if ((s % 2) == 0) begin
        mq.push_back(h[0]);
        mq.push_back(h[1]);
      end
      for (int j = 0; j < 32; j++) mq.push_back(d[j]);
    end
    for (int j = 0; j < 32; j++) begin
      if (mq.size() > 0) w[j] = mq.pop_front();
      else w[j] = 1'b0;
    end
  endtask

  task automatic random_cycle();
    logic [31:0] d;
    logic [1:0]  h;
    logic [31:0] w;
    d = $urandom;
    h = 2'($urandom_range(1, 2));
    model_step(exp_seq, d, h, w);
    run_cycle(d, h, w);
  endtask

  task automatic hand_period(input bit special);
    logic [31:0] d;
    logic [1:0]  h;
    logic [31:0] w;
    for (int s = 0; s <= 32; s++) begin
      if (s == 32) begin
        d = 32'hFFFF_FFFF;
        h = 2'b11;
      end else if (special && s == 0) begin
        d = 32'hFFFF_FFFF;
        h = 2'b01;
      end else if ((s % 2) == 0) begin
        d = 32'h0000_0000;
        h = 2'b10;
      end else begin
        d = 32'h0000_0000;
        h = 2'b11;
      end
      if (special && s == 0) w = 32'hFFFF_FFFD;
      else if (special && s == 1) w = 32'h0000_0003;
      else w = hand_word(s, special);
      run_cycle(d, h, w);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    drive(32'hA5A5_A5A5, 2'b01);
    repeat (3) @(posedge i_clk);
    #1;
    check_val("reset_data_reg", if_r.o_data, 32'd0);
    check_val("reset_data_comb", if_c.o_data, 32'd0);
    check_val("reset_seq", {26'd0, if_r.o_seq}, 32'd0);
    check_val("reset_ready", {31'd0, if_r.o_ready}, 32'd1);
    i_reset = 1'b0;
    exp_seq = 0;

    // All-zero frames with header 2'b10: header marks at bits 66k+1.
    hand_period(1'b0);
    // Frame 0 all-ones low half, then zero frames.
    hand_period(1'b1);

    // Pseudo-random frames over three periods.
    for (int i = 0; i < 99; i++) random_cycle();

    // Reset in the middle of a period.
    for (int i = 0; i < 17; i++) random_cycle();
    i_reset = 1'b1;
    drive($urandom, 2'b10);
    #1;
    check_val("midrst_data_comb", if_c.o_data, 32'd0);
    @(posedge i_clk);
    #1;
    check_val("midrst_seq", {26'd0, if_r.o_seq}, 32'd0);
    check_val("midrst_data_reg", if_r.o_data, 32'd0);
    check_val("midrst_ready", {31'd0, if_r.o_ready}, 32'd1);
    i_reset = 1'b0;
    mq.delete();
    exp_seq = 0;
    hand_period(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
